// File: rtl/ic_req_fifo_if.sv
// rtl/ic_req_fifo_if.sv - flit request queue handshake bundle
interface ic_req_fifo_if #(
    parameter int FLIT_W = 16,
    parameter int CNT_W  = 5
);
    logic [FLIT_W-1:0] flit_in;
    logic [1:0]        ctrl_in;
    logic              v_flit_in;
    logic              req_fifo_rdy;
    logic              en_pop;
    logic [FLIT_W-1:0] flit_out;
    logic [1:0]        ctrl_out;
    logic              v_flit_out;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              ovf_err;

    modport master (
        output flit_in, ctrl_in, v_flit_in, en_pop,
        input  req_fifo_rdy, flit_out, ctrl_out, v_flit_out, fifo_cnt, ovf_err
    );

    modport slave (
        input  flit_in, ctrl_in, v_flit_in, en_pop,
        output req_fifo_rdy, flit_out, ctrl_out, v_flit_out, fifo_cnt, ovf_err
    );
endinterface

// File: rtl/ic_req_fifo.sv
// rtl/ic_req_fifo.sv - packet-aware flit FIFO, presents flits only once their tail is stored
module ic_req_fifo #(
    parameter int DEPTH  = 16,
    parameter int FLIT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    ic_req_fifo_if.slave  fifo_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [FLIT_W+1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     pkt_q, pkt_d;
    logic              ovf_q, ovf_d;

    logic              rdy;
    logic              not_empty;
    logic              v_out;
    logic              push;
    logic              pop;
    logic              push_tail;
    logic              pop_tail;
    logic [FLIT_W+1:0] head;

    assign rdy       = (cnt_q != CW'(DEPTH));
    assign not_empty = (cnt_q != '0);
    assign v_out     = not_empty && (pkt_q != '0);
    assign head      = mem_q[rd_ptr_q];

    assign push      = fifo_if.v_flit_in && rdy && (fifo_if.ctrl_in != 2'b00);
    assign pop       = fifo_if.en_pop && v_out;
    assign push_tail = push && (fifo_if.ctrl_in == 2'b11);
    assign pop_tail  = pop && (head[FLIT_W+1:FLIT_W] == 2'b11);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - CW'(1);
        end

        pkt_d = pkt_q;
        if (push_tail && !pop_tail) begin
            pkt_d = pkt_q + CW'(1);
        end else if (!push_tail && pop_tail) begin
            pkt_d = pkt_q - CW'(1);
        end

        // Rejected pushes (full or invalid type) latch the error until reset.
        ovf_d = ovf_q | (fifo_if.v_flit_in && (!rdy || (fifo_if.ctrl_in == 2'b00)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pkt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pkt_q    <= pkt_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; occupancy gating below keeps stale entries invisible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {fifo_if.ctrl_in, fifo_if.flit_in};
        end
    end

    assign fifo_if.req_fifo_rdy = rdy;
    assign fifo_if.v_flit_out   = v_out;
    assign fifo_if.fifo_cnt     = cnt_q;
    assign fifo_if.ovf_err      = ovf_q;
    assign fifo_if.flit_out     = not_empty ? head[FLIT_W-1:0] : '0;
    assign fifo_if.ctrl_out     = not_empty ? head[FLIT_W+1:FLIT_W] : 2'b00;
endmodule

// File: tb/tb_ic_req_fifo.sv
// tb/tb_ic_req_fifo.sv - randomized and directed checks of ic_req_fifo against a queue model
module tb_ic_req_fifo;
    localparam int DEPTH  = 16;
    localparam int FLIT_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    bit   cmp_en = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ic_req_fifo_if #(.FLIT_W(FLIT_W), .CNT_W(5)) bus ();

    ic_req_fifo #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .fifo_if (bus.slave)
    );

    logic [17:0] mq [$];
    bit          movf;

    function automatic int m_tails();
        int n = 0;
        foreach (mq[i]) if (mq[i][17:16] == 2'b11) n++;
        return n;
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) && (m_tails() != 0);
    endfunction

    function automatic bit m_push_ok();
        return bus.v_flit_in && (bus.ctrl_in != 2'b00) && (mq.size() != DEPTH);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            movf <= 1'b0;
        end else begin
            if (bus.v_flit_in && !m_push_ok()) movf <= 1'b1;
            case ({m_push_ok(), bus.en_pop && m_valid()})
                2'b10: mq.push_back({bus.ctrl_in, bus.flit_in});
                2'b01: void'(mq.pop_front());
                2'b11: begin
                    void'(mq.pop_front());
                    mq.push_back({bus.ctrl_in, bus.flit_in});
                end
                default: ;
            endcase
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && cmp_en) begin
            chk("cmp_cnt",  32'(bus.fifo_cnt), 32'(mq.size()));
            chk("cmp_rdy",  32'(bus.req_fifo_rdy), 32'(mq.size() != DEPTH));
            chk("cmp_vout", 32'(bus.v_flit_out), 32'(m_valid()));
            chk("cmp_ovf",  32'(bus.ovf_err), 32'(movf));
            chk("cmp_flit", 32'(bus.flit_out), (mq.size() != 0) ? 32'(mq[0][15:0]) : 32'h0);
            chk("cmp_ctrl", 32'(bus.ctrl_out), (mq.size() != 0) ? 32'(mq[0][17:16]) : 32'h0);
        end
    end

    task automatic step(input logic v, input logic [1:0] c, input logic [15:0] f, input logic p);
        bus.v_flit_in = v;
        bus.ctrl_in   = c;
        bus.flit_in   = f;
        bus.en_pop    = p;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        bus.v_flit_in = 1'b0;
        bus.en_pop    = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic expect_out(input string nm, input logic [15:0] f, input logic [1:0] c);
        chk({nm, "_flit"}, 32'(bus.flit_out), 32'(f));
        chk({nm, "_ctrl"}, 32'(bus.ctrl_out), 32'(c));
        chk({nm, "_v"},    32'(bus.v_flit_out), 32'h1);
    endtask

    initial begin
        bus.v_flit_in = 1'b0;
        bus.ctrl_in   = 2'b00;
        bus.flit_in   = '0;
        bus.en_pop    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",  32'(bus.fifo_cnt), 32'h0);
        chk("rst_rdy",  32'(bus.req_fifo_rdy), 32'h1);
        chk("rst_vout", 32'(bus.v_flit_out), 32'h0);
        chk("rst_ovf",  32'(bus.ovf_err), 32'h0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Basic packet: held back until its tail lands, then drained in order.
        step(1, 2'b01, 16'h1234, 0);
        chk("p1_v_after_head", 32'(bus.v_flit_out), 32'h0);
        step(1, 2'b10, 16'h5678, 0);
        chk("p1_v_after_body", 32'(bus.v_flit_out), 32'h0);
        step(1, 2'b11, 16'habcd, 0);
        expect_out("p1_stored", 16'h1234, 2'b01);
        chk("p1_cnt", 32'(bus.fifo_cnt), 32'h3);
        step(0, 2'b00, 16'h0, 1);
        expect_out("p1_pop1", 16'h5678, 2'b10);
        step(0, 2'b00, 16'h0, 1);
        expect_out("p1_pop2", 16'habcd, 2'b11);
        step(0, 2'b00, 16'h0, 1);
        chk("p1_empty_v",    32'(bus.v_flit_out), 32'h0);
        chk("p1_empty_cnt",  32'(bus.fifo_cnt), 32'h0);
        chk("p1_empty_ctrl", 32'(bus.ctrl_out), 32'h0);

        // Incomplete packet ignores en_pop until the tail arrives.
        step(1, 2'b01, 16'hc0de, 0);
        step(1, 2'b10, 16'h2016, 0);
        step(0, 2'b00, 16'h0, 1);
        step(0, 2'b00, 16'h0, 1);
        chk("p2_hold_v",   32'(bus.v_flit_out), 32'h0);
        chk("p2_hold_cnt", 32'(bus.fifo_cnt), 32'h2);
        step(1, 2'b11, 16'hc0de, 1);
        expect_out("p2_ready", 16'hc0de, 2'b01);
        step(0, 2'b00, 16'h0, 1);
        expect_out("p2_pop1", 16'h2016, 2'b10);
        step(0, 2'b00, 16'h0, 1);
        expect_out("p2_pop2", 16'hc0de, 2'b11);
        step(0, 2'b00, 16'h0, 1);
        chk("p2_drained", 32'(bus.fifo_cnt), 32'h0);

        // Streaming push+pop every cycle across the pointer wrap.
        step(1, 2'b01, 16'h0100, 0);
        step(1, 2'b10, 16'h0101, 0);
        step(1, 2'b11, 16'h0102, 0);
        for (int i = 0; i < 45; i++) begin
            step(1, 2'((i % 3) + 1), 16'(16'h0200 + i), 1);
            chk("stream_cnt", 32'(bus.fifo_cnt), 32'h3);
            chk("stream_v",   32'(bus.v_flit_out), 32'h1);
        end
        repeat (3) step(0, 2'b00, 16'h0, 1);
        chk("stream_drained", 32'(bus.fifo_cnt), 32'h0);

        // Fill to capacity: 5 packets plus a dangling head.
        for (int p = 0; p < 5; p++) begin
            for (int k = 0; k < 3; k++) step(1, 2'(k + 1), 16'(p * 16 + k), 0);
        end
        step(1, 2'b01, 16'h00ff, 0);
        chk("full_cnt", 32'(bus.fifo_cnt), 32'd16);
        chk("full_rdy", 32'(bus.req_fifo_rdy), 32'h0);
        step(1, 2'b01, 16'hdead, 0);
        chk("full_ovf", 32'(bus.ovf_err), 32'h1);
        chk("full_cnt_hold", 32'(bus.fifo_cnt), 32'd16);
        step(0, 2'b00, 16'h0, 1);
        chk("full_pop_rdy", 32'(bus.req_fifo_rdy), 32'h1);
        chk("full_pop_cnt", 32'(bus.fifo_cnt), 32'd15);
        pulse_reset();
        chk("ovf_cleared", 32'(bus.ovf_err), 32'h0);

        step(1, 2'b00, 16'h1111, 0);
        chk("inv_ctrl_ovf", 32'(bus.ovf_err), 32'h1);
        chk("inv_ctrl_cnt", 32'(bus.fifo_cnt), 32'h0);
        pulse_reset();

        // Asynchronous reset between edges with 5 flits held.
        for (int k = 0; k < 5; k++) step(1, 2'((k % 3) + 1), 16'(16'h0a00 + k), 0);
        bus.v_flit_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cnt",  32'(bus.fifo_cnt), 32'h0);
        chk("arst_rdy",  32'(bus.req_fifo_rdy), 32'h1);
        chk("arst_vout", 32'(bus.v_flit_out), 32'h0);
        chk("arst_flit", 32'(bus.flit_out), 32'h0);
        chk("arst_ctrl", 32'(bus.ctrl_out), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 2'b01, 16'h1234, 0);
        step(1, 2'b10, 16'h5678, 0);
        step(1, 2'b11, 16'habcd, 0);
        expect_out("arst_pkt", 16'h1234, 2'b01);
        repeat (3) step(0, 2'b00, 16'h0, 1);
        chk("arst_drained", 32'(bus.fifo_cnt), 32'h0);

        // Random traffic against the model, mostly honouring req_fifo_rdy.
        for (int i = 0; i < 2000; i++) begin
            logic       v;
            logic [1:0] c;
            v = ($urandom_range(0, 3) != 0);
            if (!bus.req_fifo_rdy && ($urandom_range(0, 7) != 0)) v = 1'b0;
            c = ($urandom_range(0, 63) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
            step(v, c, 16'($urandom), ($urandom_range(0, 2) != 0));
            if (i == 1000) pulse_reset();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
